// File: rtl/hi_lo_muldiv_pkg.sv
// hi_lo_pkg: shared types for the HI/LO multiply/divide unit.
//   op_t       : 4-bit operation code issued by the decoder
//   md_state_t : sequencing state of the unit
//   helpers    : classify an op code as signed / multiply-family / divide-family
package hi_lo_pkg;

  typedef enum logic [3:0] {
    MTHI  = 4'd0,
    MTLO  = 4'd1,
    MULT  = 4'd2,
    MULTU = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    DIV   = 4'd8,
    DIVU  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  function automatic logic op_is_signed(input op_t op);
    return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
  endfunction

  function automatic logic op_is_mul(input op_t op);
    return (op == MULT) || (op == MULTU) || (op == MADD) ||
           (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  function automatic logic op_is_div(input op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/hi_lo_muldiv_if.sv
// hi_lo_muldiv_if: issue/result bundle between decoder and HI/LO unit.
//   master (decoder side): drives start, op, a, b; reads busy, done, div_zero, hi_out, lo_out
//   slave  (unit side)   : the reverse
interface hi_lo_muldiv_if #(
  parameter int WIDTH = 32
);
  import hi_lo_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/hi_lo_muldiv_div_core.sv
// div_core: unsigned restoring divider, one quotient bit per clock.
//   clk, reset          : clock, asynchronous active-high reset
//   load                : capture dividend/divisor and start WIDTH iterations
//   dividend, divisor   : unsigned operands
//   quotient, remainder : results, final once valid is high
//   valid               : no iterations outstanding
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;   // dividend shifts out the top, quotient bits shift in below
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // One extra bit so the trial subtraction's borrow lands in w_diff[WIDTH].
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_count <= '0;
    end else if (load) begin
      r_quo   <= dividend;
      r_rem   <= '0;
      r_dvs   <= divisor;
      r_count <= CW'(WIDTH);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign valid     = (r_count == '0);
endmodule

// File: rtl/hi_lo_muldiv.sv
// hi_lo_muldiv: HI/LO register pair with move-to, multiply, multiply-accumulate
// and iterative divide.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : slave side of hi_lo_muldiv_if (start/op/a/b in; busy/done/div_zero/hi_out/lo_out out)
module hi_lo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  hi_lo_muldiv_if.slave  bus
);
  import hi_lo_pkg::*;

  localparam int IW = $clog2(WIDTH);

  md_state_t          r_state, w_state_next;
  op_t                r_op;
  logic [WIDTH-1:0]   r_hi, r_lo, r_a;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_done, r_div_zero, r_b_zero, r_neg_q, r_neg_r;
  logic [IW-1:0]      r_iter;

  logic               w_accept, w_signed, w_sgn_a, w_sgn_b, w_load, w_busy;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_q_fix, w_r_fix;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_mul_res;
  logic               w_div_valid;

  assign w_accept = bus.start && (r_state == ST_IDLE);
  assign w_signed = op_is_signed(bus.op);

  // Extending both operands to 2*WIDTH and multiplying modulo 2^(2*WIDTH)
  // yields the correct two's-complement product for the signed ops too.
  assign w_a_ext = w_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign w_b_ext = w_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    w_mul_res = r_prod;
    if ((r_op == MADD) || (r_op == MADDU)) w_mul_res = {r_hi, r_lo} + r_prod;
    else if ((r_op == MSUB) || (r_op == MSUBU)) w_mul_res = {r_hi, r_lo} - r_prod;
  end

  // Magnitudes for the unsigned core. The most-negative value negates to
  // itself, which read unsigned is exactly its magnitude, so overflow
  // (most-negative / -1) falls out with no special case.
  assign w_sgn_a = w_signed && bus.a[WIDTH-1];
  assign w_sgn_b = w_signed && bus.b[WIDTH-1];
  assign w_mag_a = w_sgn_a ? -bus.a : bus.a;
  assign w_mag_b = w_sgn_b ? -bus.b : bus.b;
  assign w_load  = w_accept && op_is_div(bus.op);

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .dividend  (w_mag_a),
    .divisor   (w_mag_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .valid     (w_div_valid)
  );

  assign w_q_fix = r_neg_q ? -w_quo : w_quo;
  assign w_r_fix = r_neg_r ? -w_rem : w_rem;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && op_is_mul(bus.op))      w_state_next = ST_MUL;
        else if (w_accept && op_is_div(bus.op)) w_state_next = ST_DIV;
      end
      ST_MUL:  w_state_next = ST_IDLE;
      ST_DIV:  if (r_iter == '0) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy = (r_state != ST_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= MTHI;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a        <= '0;
      r_prod     <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_b_zero   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_iter     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= bus.op;
            if (bus.op == MTHI)          r_hi <= bus.a;
            else if (bus.op == MTLO)     r_lo <= bus.a;
            else if (op_is_mul(bus.op))  r_prod <= w_prod;
            else if (op_is_div(bus.op)) begin
              r_a        <= bus.a;
              r_b_zero   <= (bus.b == '0);
              r_neg_q    <= w_sgn_a ^ w_sgn_b;
              r_neg_r    <= w_sgn_a;
              r_div_zero <= 1'b0;
              r_iter     <= IW'(WIDTH - 1);
            end
          end
        end
        ST_MUL: begin
          {r_hi, r_lo} <= w_mul_res;
          r_done       <= 1'b1;
        end
        ST_DIV: r_iter <= r_iter - 1'b1;
        ST_FIX: begin
          if (w_div_valid) begin
            r_done     <= 1'b1;
            r_div_zero <= r_b_zero;
            if (r_b_zero) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;
endmodule

// File: tb/tb_hi_lo_muldiv.sv
module tb_hi_lo_muldiv;
  import hi_lo_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   nbusy;
  int   ndone;
  logic [31:0] lo_mid;

  hi_lo_muldiv_if #(.WIDTH(32)) bus ();

  hi_lo_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Issues one op, then follows it until busy drops; counts busy cycles and
  // done pulses (including one idle cycle after the result). With inject set,
  // an MTLO 7 is presented for one cycle mid-operation and LO is sampled
  // right after it in lo_out_mid.
  task automatic run_op(input op_t op, input logic [31:0] av, input logic [31:0] bv,
                        input bit inject, output int nb, output int nd,
                        output logic [31:0] lo_out_mid);
    int cyc;
    nb = 0;
    nd = 0;
    lo_out_mid = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h0;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      nb++;
      if (bus.done) nd++;
      if (inject && cyc == 5) begin
        bus.start = 1'b1; bus.op = MTLO; bus.a = 32'd7;
      end else if (inject && cyc == 6) begin
        bus.start = 1'b0;
        lo_out_mid = bus.lo_out;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      n_cmp++;
      n_err++;
      $error("FAIL busy_timeout: observed busy for %0d cycles required release", cyc);
    end
    if (bus.done) nd++;
    @(negedge clk);
    if (bus.done) nd++;
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0b busy_cycles=%0d done_pulses=%0d",
             op, av, bv, bus.hi_out, bus.lo_out, bus.div_zero, nb, nd);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = MTHI; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    check("rst_hi", bus.hi_out, 0);
    check("rst_lo", bus.lo_out, 0);

    // MTHI then MTLO on consecutive cycles
    bus.start = 1'b1; bus.op = MTHI; bus.a = 32'h12345678;
    @(negedge clk);
    check("mthi_busy", bus.busy, 0);
    check("mthi_hi", bus.hi_out, 32'h12345678);
    bus.op = MTLO; bus.a = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_busy", bus.busy, 0);
    check("mtlo_done", bus.done, 0);
    check("mt_hi", bus.hi_out, 32'h12345678);
    check("mt_lo", bus.lo_out, 32'h9ABCDEF0);
    $display("mthi/mtlo -> hi=%08h lo=%08h", bus.hi_out, bus.lo_out);

    // Multiply family
    run_op(MULT, 32'hFFFFFFFE, 32'd3, 1'b0, nbusy, ndone, lo_mid);
    check("mult_hi", bus.hi_out, 32'hFFFFFFFF);
    check("mult_lo", bus.lo_out, 32'hFFFFFFFA);
    check("mult_busy", nbusy, 1);
    check("mult_done", ndone, 1);
    run_op(MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, nbusy, ndone, lo_mid);
    check("multu_hi", bus.hi_out, 32'h00000002);
    check("multu_lo", bus.lo_out, 32'hFFFFFFFA);

    // Accumulate across the HI/LO boundary
    run_op(MTHI, 32'h0, 32'h0, 1'b0, nbusy, ndone, lo_mid);
    run_op(MTLO, 32'hFFFFFFFF, 32'h0, 1'b0, nbusy, ndone, lo_mid);
    check("mt_done", ndone, 0);
    run_op(MADDU, 32'd1, 32'd1, 1'b0, nbusy, ndone, lo_mid);
    check("maddu_hi", bus.hi_out, 32'd1);
    check("maddu_lo", bus.lo_out, 32'd0);
    run_op(MSUB, 32'd1, 32'd1, 1'b0, nbusy, ndone, lo_mid);
    check("msub_hi", bus.hi_out, 32'd0);
    check("msub_lo", bus.lo_out, 32'hFFFFFFFF);
    // signed accumulate of a negative product: 0x00000000_FFFFFFFF + (-2*3) = 0x00000000_FFFFFFF9
    run_op(MADD, 32'hFFFFFFFE, 32'd3, 1'b0, nbusy, ndone, lo_mid);
    check("madd_hi", bus.hi_out, 32'd0);
    check("madd_lo", bus.lo_out, 32'hFFFFFFF9);

    // Undefined op code: no busy, no done, registers untouched
    run_op(op_t'(4'hF), 32'h55555555, 32'h3, 1'b0, nbusy, ndone, lo_mid);
    check("nop_busy", nbusy, 0);
    check("nop_done", ndone, 0);
    check("nop_lo", bus.lo_out, 32'hFFFFFFF9);

    // Divide family
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 1'b0, nbusy, ndone, lo_mid);
    check("div_lo", bus.lo_out, 32'hFFFFFFFD);
    check("div_hi", bus.hi_out, 32'hFFFFFFFF);
    check("div_busy", nbusy, 33);
    check("div_done", ndone, 1);
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, nbusy, ndone, lo_mid);
    check("divovf_lo", bus.lo_out, 32'h80000000);
    check("divovf_hi", bus.hi_out, 32'h0);
    check("divovf_busy", nbusy, 33);
    check("divovf_dz", bus.div_zero, 0);

    // Divide by zero with a start presented mid-divide
    run_op(DIVU, 32'd5, 32'd0, 1'b1, nbusy, ndone, lo_mid);
    check("dz_inject_lo", lo_mid, 32'h80000000);
    check("dz_lo", bus.lo_out, 32'hFFFFFFFF);
    check("dz_hi", bus.hi_out, 32'd5);
    check("dz_flag", bus.div_zero, 1);
    check("dz_busy", nbusy, 33);
    check("dz_done", ndone, 1);
    run_op(DIVU, 32'd9, 32'd3, 1'b0, nbusy, ndone, lo_mid);
    check("divu_lo", bus.lo_out, 32'd3);
    check("divu_hi", bus.hi_out, 32'd0);
    check("divu_dz", bus.div_zero, 0);

    // Reset in the middle of a divide
    run_op(MTHI, 32'hAAAA5555, 32'h0, 1'b0, nbusy, ndone, lo_mid);
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_hi", bus.hi_out, 0);
    check("midrst_lo", bus.lo_out, 0);
    $display("reset mid-divide -> busy=%0b hi=%08h lo=%08h", bus.busy, bus.hi_out, bus.lo_out);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(MTLO, 32'd1, 32'd0, 1'b0, nbusy, ndone, lo_mid);
    check("post_rst_lo", bus.lo_out, 32'd1);
    check("post_rst_hi", bus.hi_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
